// File: rtl/led_bank_arbiter.sv
// Round-robin owner arbitration for the board LED bank, with minimum/maximum hold times.
// Optional feature macro: LED_ARB_HEARTBEAT_EN (heartbeat on led[LED_W-1] while idle).
module led_bank_arbiter #(
    parameter int NREQ     = 4,
    parameter int LED_W    = 4,
    parameter int MIN_HOLD = 1024,
    parameter int MAX_HOLD = 1048576,
    parameter int HB_DIV   = 24
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NREQ-1:0]         req,
    input  logic [NREQ*LED_W-1:0]   req_led,
    output logic [NREQ-1:0]         gnt,
    output logic [LED_W-1:0]        led,
    output logic                    busy
);

    localparam int PW  = $clog2(NREQ);
    localparam int PW1 = PW + 1;
    localparam int HW  = $clog2(MAX_HOLD + 1);

    localparam logic [HW-1:0] MIN_LAST = HW'(MIN_HOLD - 1);
    localparam logic [HW-1:0] MAX_LAST = HW'(MAX_HOLD - 1);
    localparam logic [HW-1:0] MAX_SAT  = HW'(MAX_HOLD);
    localparam logic [PW-1:0] LAST_IDX = PW'(NREQ - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        OWN    = 2'd1,
        LINGER = 2'd2
    } state_t;

    state_t            state_reg, state_next;
    logic [PW-1:0]     owner_reg, owner_next;
    logic [PW-1:0]     rr_ptr_reg, rr_ptr_next;
    logic [HW-1:0]     hold_ctr_reg, hold_ctr_next;
    logic [NREQ-1:0]   gnt_reg, gnt_next;
    logic [LED_W-1:0]  led_reg, led_next;
    logic              busy_reg, busy_next;

    logic [LED_W-1:0]  pattern [NREQ];
    logic [LED_W-1:0]  owner_pattern;
    logic [LED_W-1:0]  idle_led;
    logic              hb_msb;
    logic              owner_req;
    logic              others_wait;
    logic              hold_min_met;
    logic              hold_max_hit;
    logic [HW-1:0]     hold_inc;
    logic [PW-1:0]     rr_after_owner;
    logic              release_now;

    logic              found;
    logic [PW-1:0]     winner;
    logic [PW1-1:0]    probe;

    // Unpack the flat pattern bus into one slot per requester.
    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_pattern
            assign pattern[gi] = req_led[gi*LED_W +: LED_W];
        end
    endgenerate

`ifdef LED_ARB_HEARTBEAT_EN
    logic [HB_DIV-1:0] hb_ctr_reg;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hb_ctr_reg <= '0;
        end else begin
            hb_ctr_reg <= hb_ctr_reg + HB_DIV'(1);
        end
    end

    assign hb_msb = hb_ctr_reg[HB_DIV-1];
`else
    // No heartbeat in this build: constant low.
    assign hb_msb = (HB_DIV < 0);
`endif

    always_comb begin
        idle_led            = '0;
        idle_led[LED_W-1]   = hb_msb;
    end

    // First set request at or above rr_ptr, wrapping past NREQ-1 back to 0.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        probe  = '0;
        for (int k = 0; k < NREQ; k++) begin
            probe = PW1'(rr_ptr_reg) + PW1'(k);
            if (probe >= PW1'(NREQ)) begin
                probe = probe - PW1'(NREQ);
            end
            if (!found && req[probe[PW-1:0]]) begin
                found  = 1'b1;
                winner = probe[PW-1:0];
            end
        end
    end

    assign owner_req      = req[owner_reg];
    assign owner_pattern  = pattern[owner_reg];
    assign others_wait    = |(req & ~gnt_reg);
    assign hold_min_met   = (hold_ctr_reg >= MIN_LAST);
    assign hold_max_hit   = (hold_ctr_reg >= MAX_LAST);
    assign hold_inc       = (hold_ctr_reg == MAX_SAT) ? hold_ctr_reg : hold_ctr_reg + HW'(1);
    assign rr_after_owner = (owner_reg == LAST_IDX) ? '0 : owner_reg + PW'(1);

    always_comb begin
        state_next    = state_reg;
        owner_next    = owner_reg;
        rr_ptr_next   = rr_ptr_reg;
        hold_ctr_next = hold_ctr_reg;
        gnt_next      = gnt_reg;
        led_next      = led_reg;
        release_now   = 1'b0;

        case (state_reg)
            IDLE: begin
                gnt_next = '0;
                led_next = idle_led;
                if (found) begin
                    owner_next    = winner;
                    gnt_next      = {{(NREQ-1){1'b0}}, 1'b1} << winner;
                    hold_ctr_next = '0;
                    state_next    = OWN;
                end
            end
            OWN: begin
                hold_ctr_next = hold_inc;
                led_next      = owner_pattern;
                if (!owner_req) begin
                    if (hold_min_met) begin
                        release_now = 1'b1;
                    end else begin
                        state_next = LINGER;
                    end
                end else if (hold_max_hit && others_wait) begin
                    release_now = 1'b1;
                end
            end
            LINGER: begin
                // Pattern frozen and request ignored until the minimum hold expires.
                hold_ctr_next = hold_inc;
                if (hold_min_met) begin
                    release_now = 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
                gnt_next   = '0;
                led_next   = '0;
            end
        endcase

        if (release_now) begin
            state_next  = IDLE;
            gnt_next    = '0;
            led_next    = '0;
            rr_ptr_next = rr_after_owner;
        end
    end

    assign busy_next = (state_next != IDLE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg    <= IDLE;
            owner_reg    <= '0;
            rr_ptr_reg   <= '0;
            hold_ctr_reg <= '0;
            gnt_reg      <= '0;
            led_reg      <= '0;
            busy_reg     <= 1'b0;
        end else begin
            state_reg    <= state_next;
            owner_reg    <= owner_next;
            rr_ptr_reg   <= rr_ptr_next;
            hold_ctr_reg <= hold_ctr_next;
            gnt_reg      <= gnt_next;
            led_reg      <= led_next;
            busy_reg     <= busy_next;
        end
    end

    assign gnt  = gnt_reg;
    assign led  = led_reg;
    assign busy = busy_reg;

endmodule

// File: tb/tb_led_bank_arbiter.sv
// Directed, table-driven bench for led_bank_arbiter (NREQ=4, LED_W=4, MIN_HOLD=4, MAX_HOLD=16).
module tb_led_bank_arbiter;

    localparam int NREQ  = 4;
    localparam int LED_W = 4;

    logic                  clk;
    logic                  reset;
    logic [NREQ-1:0]       req;
    logic [NREQ*LED_W-1:0] req_led;
    logic [NREQ-1:0]       gnt;
    logic [LED_W-1:0]      led;
    logic                  busy;

    int checks = 0;
    int errors = 0;

    led_bank_arbiter #(
        .NREQ     (NREQ),
        .LED_W    (LED_W),
        .MIN_HOLD (4),
        .MAX_HOLD (16),
        .HB_DIV   (3)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .req     (req),
        .req_led (req_led),
        .gnt     (gnt),
        .led     (led),
        .busy    (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [NREQ-1:0]       req;
        logic [NREQ*LED_W-1:0] rl;
        logic [NREQ-1:0]       gnt;
        logic [LED_W-1:0]      led;
        logic                  busy;
    } vec_t;

    vec_t vecs [17];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_outs(input string name, input logic [3:0] eg, input logic [3:0] el, input logic eb);
        chk({name, ".gnt"},  32'(gnt),  32'(eg));
        chk({name, ".led"},  32'(led),  32'(el));
        chk({name, ".busy"}, 32'(busy), 32'(eb));
    endtask

    task automatic pulse_reset();
        req     = '0;
        req_led = '0;
        reset   = 1'b0;
        tick();
        tick();
        reset   = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Rows run back to back from IDLE with rr_ptr=0.
        // Single request on slot 2, pattern change, release at the hold limit.
        vecs[0]  = '{4'b0100, 16'h0A00, 4'b0100, 4'h0, 1'b1};
        vecs[1]  = '{4'b0100, 16'h0A00, 4'b0100, 4'hA, 1'b1};
        vecs[2]  = '{4'b0100, 16'h0300, 4'b0100, 4'h3, 1'b1};
        vecs[3]  = '{4'b0100, 16'h0300, 4'b0100, 4'h3, 1'b1};
        vecs[4]  = '{4'b0000, 16'h0300, 4'b0000, 4'h0, 1'b0};
        // Short pulse on slot 0: linger, ignore re-assertion, release at hold_ctr=3.
        vecs[5]  = '{4'b0001, 16'h0005, 4'b0001, 4'h0, 1'b1};
        vecs[6]  = '{4'b0001, 16'h0005, 4'b0001, 4'h5, 1'b1};
        vecs[7]  = '{4'b0000, 16'h0005, 4'b0001, 4'h5, 1'b1};
        vecs[8]  = '{4'b0001, 16'h000F, 4'b0001, 4'h5, 1'b1};
        vecs[9]  = '{4'b0000, 16'h000F, 4'b0000, 4'h0, 1'b0};
        // rr_ptr=1 picks slot 2 over slot 0; slot 2 release wraps rr_ptr to 3 -> slot 0 next.
        vecs[10] = '{4'b0101, 16'h0201, 4'b0100, 4'h0, 1'b1};
        vecs[11] = '{4'b0101, 16'h0201, 4'b0100, 4'h2, 1'b1};
        vecs[12] = '{4'b0001, 16'h0201, 4'b0100, 4'h2, 1'b1};
        vecs[13] = '{4'b0101, 16'h0201, 4'b0100, 4'h2, 1'b1};
        vecs[14] = '{4'b0101, 16'h0201, 4'b0000, 4'h0, 1'b0};
        vecs[15] = '{4'b0101, 16'h0201, 4'b0001, 4'h0, 1'b1};
        vecs[16] = '{4'b0000, 16'h0201, 4'b0001, 4'h1, 1'b1};

        // Reset held with all requests asserted.
        reset   = 1'b0;
        req     = 4'hF;
        req_led = 16'h4321;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk_outs("reset_hold", 4'b0000, 4'h0, 1'b0);
        end
        $display("reset held 10 cycles: gnt=%b led=%h busy=%b", gnt, led, busy);
        reset = 1'b1;
        tick();
        chk_outs("reset_exit", 4'b0001, 4'h0, 1'b1);
        $display("reset released: gnt=%b busy=%b", gnt, busy);
        reset = 1'b0;
        #1;
        chk_outs("async_reset_own", 4'b0000, 4'h0, 1'b0);
        req = '0;
        tick();
        reset = 1'b1;
        tick();
        chk_outs("idle_after_reset", 4'b0000, 4'h0, 1'b0);

        for (int v = 0; v < 17; v++) begin
            req     = vecs[v].req;
            req_led = vecs[v].rl;
            tick();
            chk_outs($sformatf("vec%0d", v), vecs[v].gnt, vecs[v].led, vecs[v].busy);
            $display("vec %0d: req=%b req_led=%h -> gnt=%b led=%h busy=%b",
                     v, vecs[v].req, vecs[v].rl, gnt, led, busy);
        end

        // Now in LINGER for slot 0: asynchronous reset mid-cycle.
        reset = 1'b0;
        #1;
        chk_outs("async_reset_linger", 4'b0000, 4'h0, 1'b0);
        req = '0;
        tick();
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_outs("idle_no_req", 4'b0000, 4'h0, 1'b0);
        end
        $display("reset in LINGER: gnt=%b led=%h busy=%b", gnt, led, busy);

        // Lone owner beyond MAX_HOLD keeps the bank; voluntary release afterwards.
        req     = 4'b0001;
        req_led = 16'h0007;
        for (int i = 0; i < 22; i++) begin
            tick();
            chk("lone_owner.gnt", 32'(gnt), 32'h1);
        end
        chk("lone_owner.led", 32'(led), 32'h7);
        req = '0;
        tick();
        chk_outs("lone_release", 4'b0000, 4'h0, 1'b0);
        $display("lone owner held 22 cycles then released: gnt=%b", gnt);

        // Full contention: 16-cycle ownerships, 1-cycle gap, order 0,1,2,3,0.
        pulse_reset();
        req     = 4'hF;
        req_led = 16'h4321;
        for (int c = 0; c < 85; c++) begin
            int p;
            int own;
            logic [3:0] eg;
            logic [3:0] el;
            p   = c % 17;
            own = (c / 17) % 4;
            eg  = (p == 16) ? 4'b0000 : (4'b0001 << own);
            el  = (p == 0 || p == 16) ? 4'h0 : 4'(own + 1);
            tick();
            chk_outs($sformatf("rr_c%0d", c), eg, el, (p != 16));
            chk("rr_onehot", 32'($onehot0(gnt)), 32'h1);
            if (p == 0) begin
                $display("round robin cycle %0d: gnt=%b", c, gnt);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
